// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage
//   Pipeline MEM stage. It sits directly upstream of WB and owns the MEM/WB
//   register. Loads and stores go to data memory over a req/gnt handshake,
//   followed by rvalid for loads. Load data is formatted by size and sign.
//   EX is stalled through in_ready while a memory access is outstanding.
//
//   Optional feature macro: MEM_MISALIGN_EXC_EN
//     defined   : a misaligned H/HU/SH or W/SW access issues no request. It
//                 retires one cycle after acceptance with misalign_out=1 and
//                 RegWrite_out=0.
//     undefined : the byte offset is aligned down to the access size, and
//                 misalign_out is tied to 0.
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   in_valid / in_ready         EX/MEM handshake (in_ready == state IDLE)
//   alu_result_in .. MemWrite_in  instruction fields captured at acceptance
//   dmem_req/we/addr/wdata/be   registered memory request (addr word-aligned)
//   dmem_gnt, dmem_rvalid,
//   dmem_rdata                  memory responses
//   out_valid                   1-cycle retirement pulse into WB
//   mem_data_out, alu_result_out, rd_addr_out,
//   RegWrite_out, MemtoReg_out,
//   misalign_out                MEM/WB register contents
// -----------------------------------------------------------------------------
module mem_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   alu_result_in,
    input  logic [XLEN-1:0]   rs2_data_in,
    input  logic [REG_AW-1:0] rd_addr_in,
    input  logic [2:0]        funct3_in,
    input  logic              RegWrite_in,
    input  logic              MemtoReg_in,
    input  logic              MemRead_in,
    input  logic              MemWrite_in,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    output logic [3:0]        dmem_be,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic              out_valid,
    output logic [XLEN-1:0]   mem_data_out,
    output logic [XLEN-1:0]   alu_result_out,
    output logic [REG_AW-1:0] rd_addr_out,
    output logic              RegWrite_out,
    output logic              MemtoReg_out,
    output logic              misalign_out
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    // Fields of an in-flight memory op, needed again at retirement.
    typedef struct packed {
        logic [XLEN-1:0]   alu;
        logic [REG_AW-1:0] rd;
        logic [2:0]        funct3;
        logic              rw;
        logic              m2r;
        logic              is_load;
    } cap_t;

    state_t state, state_next;
    cap_t   cap;

    logic            accept;
    logic            is_mem;
    logic            is_load;
    logic            misalign;
    logic            issue;
    logic            ret_direct;
    logic            ret_store;
    logic            ret_load;
    logic [1:0]      off;
    logic [3:0]      be_fmt;
    logic [XLEN-1:0] wdata_fmt;

    // Picks the byte or half selected by the offset, then extends it.
    // funct3 011/110/111 fall to the default (word) case.
    function automatic logic [XLEN-1:0] load_fmt(input logic [XLEN-1:0] rdata,
                                                 input logic [1:0]      boff,
                                                 input logic [2:0]      f3);
        logic [7:0]      b;
        logic [15:0]     h;
        logic [XLEN-1:0] r;
        case (boff)
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = boff[1] ? rdata[31:16] : rdata[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'b0, b};
            3'b101:  r = {16'b0, h};
            default: r = rdata;
        endcase
        return r;
    endfunction

    assign in_ready = (state == IDLE) && !rst;
    assign accept   = in_valid && (state == IDLE);
    assign is_mem   = MemRead_in || MemWrite_in;
    // A store wins when both MemRead_in and MemWrite_in are set.
    assign is_load  = MemRead_in && !MemWrite_in;
    assign off      = alu_result_in[1:0];

`ifdef MEM_MISALIGN_EXC_EN
    always_comb begin
        misalign = 1'b0;
        if (is_mem) begin
            case (funct3_in[1:0])
                2'b00:   misalign = 1'b0;
                2'b01:   misalign = off[0];
                default: misalign = (off != 2'b00);
            endcase
        end
    end
`else
    assign misalign = 1'b0;
`endif

    // Only an aligned (or silently aligned) memory op goes to the bus.
    // Everything else retires straight through on the next cycle.
    assign issue      = accept && is_mem && !misalign;
    assign ret_direct = accept && !issue;
    assign ret_store  = (state == REQ)  && dmem_gnt && !cap.is_load;
    assign ret_load   = (state == WAIT) && dmem_rvalid;

    // Store lane steering. The size field is funct3[1:0], so 011/110/111
    // land in the word case. Low offset bits below the access size are
    // ignored, which aligns sub-word accesses down.
    always_comb begin
        be_fmt    = 4'b1111;
        wdata_fmt = rs2_data_in;
        case (funct3_in[1:0])
            2'b00: begin
                be_fmt    = 4'b0001 << off;
                wdata_fmt = {4{rs2_data_in[7:0]}};
            end
            2'b01: begin
                be_fmt    = off[1] ? 4'b1100 : 4'b0011;
                wdata_fmt = {2{rs2_data_in[15:0]}};
            end
            default: begin
                be_fmt    = 4'b1111;
                wdata_fmt = rs2_data_in;
            end
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (issue)       state_next = REQ;
            REQ:     if (dmem_gnt)    state_next = cap.is_load ? WAIT : IDLE;
            WAIT:    if (dmem_rvalid) state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Capture the memory op. The request registers stay stable in REQ
    // because they are written only on issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap        <= '0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_be    <= '0;
        end else begin
            if (issue) begin
                cap.alu     <= alu_result_in;
                cap.rd      <= rd_addr_in;
                cap.funct3  <= funct3_in;
                cap.rw      <= RegWrite_in;
                cap.m2r     <= MemtoReg_in;
                cap.is_load <= is_load;
                dmem_req    <= 1'b1;
                dmem_we     <= MemWrite_in;
                dmem_addr   <= {alu_result_in[XLEN-1:2], 2'b00};
                dmem_wdata  <= wdata_fmt;
                dmem_be     <= be_fmt;
            end else if ((state == REQ) && dmem_gnt) begin
                dmem_req    <= 1'b0;
            end
        end
    end

    // MEM/WB register. out_valid, RegWrite_out and misalign_out are pulses.
    // The data fields hold their value between retirements.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid      <= 1'b0;
            mem_data_out   <= '0;
            alu_result_out <= '0;
            rd_addr_out    <= '0;
            RegWrite_out   <= 1'b0;
            MemtoReg_out   <= 1'b0;
            misalign_out   <= 1'b0;
        end else begin
            out_valid    <= ret_direct || ret_store || ret_load;
            misalign_out <= ret_direct && misalign;
            RegWrite_out <= 1'b0;
            if (ret_direct) begin
                alu_result_out <= alu_result_in;
                rd_addr_out    <= rd_addr_in;
                MemtoReg_out   <= MemtoReg_in;
                RegWrite_out   <= RegWrite_in && !misalign && (rd_addr_in != '0);
            end else if (ret_store || ret_load) begin
                alu_result_out <= cap.alu;
                rd_addr_out    <= cap.rd;
                MemtoReg_out   <= cap.m2r;
                RegWrite_out   <= cap.rw && (cap.rd != '0);
            end
            if (ret_load)
                mem_data_out <= load_fmt(dmem_rdata, cap.alu[1:0], cap.funct3);
        end
    end

endmodule
